uart_io_ctrl: RTL and testbench



---
 rtl/uart_io_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_io_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// UART I/O instruction controller: stalls the CPU while a send or receive
// instruction moves exactly one byte, with a one-entry rx holding buffer.
module uart_io_ctrl #(
    parameter logic [5:0]  OPCODE_SND  = 6'b010001,
    parameter logic [5:0]  OPCODE_RCV  = 6'b010010,
    parameter logic [15:0] RCV_TIMEOUT = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [7:0] snd_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cpu_stall,
    output logic [7:0] rcv_data,
    output logic       rcv_we,
    output logic       rx_overrun,
    output logic       rcv_timeout
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SND_WAIT = 3'd1;
    localparam logic [2:0] SND_BUSY = 3'd2;
    localparam logic [2:0] RCV_WAIT = 3'd3;
    localparam logic [2:0] RCV_WB   = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]  state_q,     state_d;
    logic        tx_start_q,  tx_start_d;
    logic [7:0]  tx_data_q,   tx_data_d;
    logic [7:0]  rcv_data_q,  rcv_data_d;
    logic [7:0]  rx_buf_q,    rx_buf_d;
    logic        rx_full_q,   rx_full_d;
    logic        overrun_q,   overrun_d;
    logic        timeout_q,   timeout_d;
    logic [15:0] wait_cnt_q,  wait_cnt_d;
    logic        stall;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rcv_data_d = rcv_data_q;
        rx_buf_d   = rx_buf_q;
        rx_full_d  = rx_full_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        wait_cnt_d = '0;
        stall      = 1'b0;

        // Outside RCV_WAIT nothing consumes the buffer, so a second byte overwrites it.
        if (rx_valid && (state_q != RCV_WAIT)) begin
            rx_buf_d  = rx_data;
            rx_full_d = 1'b1;
            if (rx_full_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (opcode == OPCODE_SND) begin
                    state_d = SND_WAIT;
                    stall   = 1'b1;
                end else if (opcode == OPCODE_RCV) begin
                    state_d = RCV_WAIT;
                    stall   = 1'b1;
                end
            end
            SND_WAIT: begin
                stall = 1'b1;
                if (!tx_busy) begin
                    tx_data_d  = snd_data;
                    tx_start_d = 1'b1;
                    state_d    = SND_BUSY;
                end
            end
            SND_BUSY: begin
                stall = 1'b1;
                if (tx_done) begin
                    state_d = DONE;
                end
            end
            RCV_WAIT: begin
                stall = 1'b1;
                if (rx_full_q) begin
                    rcv_data_d = rx_buf_q;
                    state_d    = RCV_WB;
                    if (rx_valid) begin
                        rx_buf_d = rx_data;
                    end else begin
                        rx_full_d = 1'b0;
                    end
                end else if (rx_valid) begin
                    rcv_data_d = rx_data;
                    state_d    = RCV_WB;
                end else if (wait_cnt_q == RCV_TIMEOUT - 16'd1) begin
                    rcv_data_d = 8'h00;
                    timeout_d  = 1'b1;
                    state_d    = RCV_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            RCV_WB: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rcv_data_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rcv_data_q <= rcv_data_d;
            rx_buf_q   <= rx_buf_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Stall is combinational so IDLE can freeze the PC in the decode cycle; reset masks it.
    assign cpu_stall   = stall && !reset;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign rcv_data    = rcv_data_q;
    assign rcv_we      = (state_q == RCV_WB);
    assign rx_overrun  = overrun_q;
    assign rcv_timeout = timeout_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: a per-cycle vector table for send/receive/overrun,
// then hand sequences for busy hold, timeout and mid-transfer reset.
module tb_uart_io_ctrl;

    localparam logic [5:0] SND = 6'b010001;
    localparam logic [5:0] RCV = 6'b010010;
    localparam logic [5:0] NOP = 6'b000000;
    localparam int NV = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [7:0] snd_data;
    logic       tx_busy, tx_done, rx_valid;
    logic [7:0] rx_data;
    logic       tx_start, cpu_stall, rcv_we, rx_overrun, rcv_timeout;
    logic [7:0] tx_data, rcv_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] op;
        logic [7:0] snd;
        logic       busy;
        logic       done;
        logic       rxv;
        logic [7:0] rxd;
        logic       ts;
        logic [7:0] td;
        logic       st;
        logic       we;
        logic [7:0] rd;
        logic       ovr;
        logic       tmo;
    } vec_t;

    vec_t vecs [NV];

    uart_io_ctrl #(
        .OPCODE_SND (SND),
        .OPCODE_RCV (RCV),
        .RCV_TIMEOUT(16'd8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .snd_data   (snd_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .cpu_stall  (cpu_stall),
        .rcv_data   (rcv_data),
        .rcv_we     (rcv_we),
        .rx_overrun (rx_overrun),
        .rcv_timeout(rcv_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [5:0] op, input logic [7:0] snd, input logic busy,
                                input logic done, input logic rxv, input logic [7:0] rxd,
                                input logic ts, input logic [7:0] td, input logic st,
                                input logic we, input logic [7:0] rd, input logic ovr,
                                input logic tmo);
        vec_t v;
        v.op = op; v.snd = snd; v.busy = busy; v.done = done; v.rxv = rxv; v.rxd = rxd;
        v.ts = ts; v.td = td; v.st = st; v.we = we; v.rd = rd; v.ovr = ovr; v.tmo = tmo;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ts, input logic [7:0] td,
                             input logic st, input logic we, input logic [7:0] rd,
                             input logic ovr, input logic tmo);
        check({tag, "_tx_start"},    8'(tx_start),    8'(ts));
        check({tag, "_tx_data"},     tx_data,         td);
        check({tag, "_cpu_stall"},   8'(cpu_stall),   8'(st));
        check({tag, "_rcv_we"},      8'(rcv_we),      8'(we));
        check({tag, "_rcv_data"},    rcv_data,        rd);
        check({tag, "_rx_overrun"},  8'(rx_overrun),  8'(ovr));
        check({tag, "_rcv_timeout"}, 8'(rcv_timeout), 8'(tmo));
    endtask

    task automatic drive(input logic [5:0] op, input logic [7:0] snd, input logic busy,
                         input logic done, input logic rxv, input logic [7:0] rxd);
        opcode   = op;
        snd_data = snd;
        tx_busy  = busy;
        tx_done  = done;
        rx_valid = rxv;
        rx_data  = rxd;
    endtask

    task automatic cycle(input logic [5:0] op, input logic [7:0] snd, input logic busy,
                         input logic done, input logic rxv, input logic [7:0] rxd);
        @(negedge clock);
        drive(op, snd, busy, done, rxv, rxd);
        #1;
    endtask

    initial begin
        //                op   snd    bsy dne rxv rxd    | ts td     st we rd     ovr tmo
        vecs[0]  = mk(SND, 8'hA5, 0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[1]  = mk(SND, 8'hA5, 0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(SND, 8'hA5, 1, 0, 0, 8'h00,  1, 8'hA5, 1, 0, 8'h00, 0, 0);
        vecs[3]  = mk(SND, 8'hA5, 1, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h00, 0, 0);
        vecs[4]  = mk(SND, 8'hA5, 0, 1, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h00, 0, 0);
        vecs[5]  = mk(SND, 8'hA5, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h00, 0, 0);
        vecs[6]  = mk(NOP, 8'h00, 0, 1, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h00, 0, 0);
        vecs[7]  = mk(NOP, 8'h00, 0, 0, 1, 8'h3C,  0, 8'hA5, 0, 0, 8'h00, 0, 0);
        vecs[8]  = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h00, 0, 0);
        vecs[9]  = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h00, 0, 0);
        vecs[10] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 8'h3C, 0, 0);
        vecs[11] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h3C, 0, 0);
        vecs[12] = mk(NOP, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h3C, 0, 0);
        vecs[13] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h3C, 0, 0);
        vecs[14] = mk(RCV, 8'h00, 0, 0, 1, 8'h5A,  0, 8'hA5, 1, 0, 8'h3C, 0, 0);
        vecs[15] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 8'h5A, 0, 0);
        vecs[16] = mk(NOP, 8'h00, 0, 0, 1, 8'h66,  0, 8'hA5, 0, 0, 8'h5A, 0, 0);
        vecs[17] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h5A, 0, 0);
        vecs[18] = mk(RCV, 8'h00, 0, 0, 1, 8'h77,  0, 8'hA5, 1, 0, 8'h5A, 0, 0);
        vecs[19] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 8'h66, 0, 0);
        vecs[20] = mk(NOP, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h66, 0, 0);
        vecs[21] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h66, 0, 0);
        vecs[22] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h66, 0, 0);
        vecs[23] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 8'h77, 0, 0);
        vecs[24] = mk(NOP, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h77, 0, 0);
        vecs[25] = mk(NOP, 8'h00, 0, 0, 1, 8'h11,  0, 8'hA5, 0, 0, 8'h77, 0, 0);
        vecs[26] = mk(NOP, 8'h00, 0, 0, 1, 8'h22,  0, 8'hA5, 0, 0, 8'h77, 0, 0);
        vecs[27] = mk(NOP, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h77, 1, 0);
        vecs[28] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h77, 1, 0);
        vecs[29] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 0, 8'h77, 1, 0);
        vecs[30] = mk(RCV, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 8'h22, 1, 0);
        vecs[31] = mk(NOP, 8'h00, 0, 0, 0, 8'h00,  0, 8'hA5, 0, 0, 8'h22, 1, 0);

        // Reset with SND decoded and an rx byte arriving: byte must be dropped, stall masked.
        reset = 1'b1;
        drive(SND, 8'h00, 0, 0, 1, 8'h99);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_all("reset", 0, 8'h00, 0, 0, 8'h00, 0, 0);
        reset = 1'b0;
        drive(NOP, 8'h00, 0, 0, 0, 8'h00);

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].op, vecs[i].snd, vecs[i].busy, vecs[i].done, vecs[i].rxv, vecs[i].rxd);
            check_all($sformatf("vec%0d", i), vecs[i].ts, vecs[i].td, vecs[i].st, vecs[i].we,
                      vecs[i].rd, vecs[i].ovr, vecs[i].tmo);
        end

        // Transmitter busy for 20 cycles: no start until it drops, then start on the next edge.
        cycle(SND, 8'hC3, 1, 0, 0, 8'h00);
        check("busy_idle_stall", 8'(cpu_stall), 8'h01);
        for (int i = 0; i < 20; i++) begin
            cycle(SND, 8'hC3, 1, 0, 0, 8'h00);
            check($sformatf("busy_hold%0d_tx_start", i), 8'(tx_start), 8'h00);
        end
        cycle(SND, 8'hC3, 0, 0, 0, 8'h00);
        check("busy_release_tx_start", 8'(tx_start), 8'h00);
        cycle(SND, 8'hFF, 1, 0, 0, 8'h00);
        check("busy_start_tx_start", 8'(tx_start), 8'h01);
        check("busy_start_tx_data", tx_data, 8'hC3);
        cycle(SND, 8'hFF, 1, 0, 0, 8'h00);
        check("busy_pulse_end", 8'(tx_start), 8'h00);
        check("busy_data_hold", tx_data, 8'hC3);
        cycle(SND, 8'hFF, 0, 1, 0, 8'h00);
        check("busy_sndbusy_stall", 8'(cpu_stall), 8'h01);
        cycle(NOP, 8'h00, 0, 0, 0, 8'h00);
        check("busy_done_stall", 8'(cpu_stall), 8'h00);

        // Data arriving in the last wait cycle beats the timeout.
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cycle(RCV, 8'h00, 0, 0, (k == 7), 8'hE7);
            check($sformatf("late%0d_rcv_we", k), 8'(rcv_we), 8'h00);
        end
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        check("late_rcv_we", 8'(rcv_we), 8'h01);
        check("late_rcv_data", rcv_data, 8'hE7);
        check("late_rcv_timeout", 8'(rcv_timeout), 8'h00);
        cycle(NOP, 8'h00, 0, 0, 0, 8'h00);
        check("late_done_stall", 8'(cpu_stall), 8'h00);

        // No data at all: write back 00 after exactly 8 wait cycles and set the sticky flag.
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
            check($sformatf("tmo%0d_rcv_we", k), 8'(rcv_we), 8'h00);
            check($sformatf("tmo%0d_stall", k), 8'(cpu_stall), 8'h01);
        end
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        check("tmo_rcv_we", 8'(rcv_we), 8'h01);
        check("tmo_rcv_data", rcv_data, 8'h00);
        check("tmo_rcv_timeout", 8'(rcv_timeout), 8'h01);
        cycle(NOP, 8'h00, 0, 0, 0, 8'h00);
        cycle(NOP, 8'h00, 0, 0, 0, 8'h00);
        check("tmo_sticky", 8'(rcv_timeout), 8'h01);

        // Reset in SND_BUSY abandons the send; a later tx_done and the dropped rx byte have no effect.
        cycle(SND, 8'h5E, 0, 0, 0, 8'h00);
        cycle(SND, 8'h5E, 0, 0, 0, 8'h00);
        cycle(SND, 8'h5E, 1, 0, 0, 8'h00);
        check("rst_pre_tx_start", 8'(tx_start), 8'h01);
        check("rst_pre_tx_data", tx_data, 8'h5E);
        @(negedge clock);
        reset = 1'b1;
        drive(SND, 8'h5E, 1, 0, 1, 8'hBB);
        #1;
        check("rst_stall_masked", 8'(cpu_stall), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        drive(NOP, 8'h00, 0, 1, 0, 8'h00);
        #1;
        check_all("rst_mid", 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(NOP, 8'h00, 0, 0, 0, 8'h00);
            check($sformatf("rst_after%0d_tx_start", i), 8'(tx_start), 8'h00);
            check($sformatf("rst_after%0d_stall", i), 8'(cpu_stall), 8'h00);
        end
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        check("rst_drop_wait_we", 8'(rcv_we), 8'h00);
        cycle(RCV, 8'h00, 0, 0, 0, 8'h00);
        check("rst_drop_rcv_we", 8'(rcv_we), 8'h00);
        check("rst_drop_rcv_data", rcv_data, 8'h00);

        @(negedge clock);
        reset = 1'b1;
        drive(NOP, 8'h00, 0, 0, 0, 8'h00);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
